// File: rtl/seq_divider_pkg.sv
// Shared definitions for the sequential divider: FSM states, ALU-compatible
// flag bit positions and the decoder opcodes that steer UDIV/SDIV here.
package seq_divider_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } div_state_t;

  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

  localparam logic [3:0] OPC_UDIV = 4'b1100;
  localparam logic [3:0] OPC_SDIV = 4'b1101;

  function automatic logic [3:0] make_flags(input logic n, input logic z, input logic v);
    logic [3:0] f;
    f         = '0;
    f[FLAG_N] = n;
    f[FLAG_Z] = z;
    f[FLAG_C] = 1'b0;
    f[FLAG_V] = v;
    return f;
  endfunction

endpackage

// File: rtl/seq_divider_step.sv
// One combinational restoring-division step: shift in the next dividend bit
// and subtract the divisor when the partial remainder allows it.
module div_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic             dvd_msb,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] next_rem,
  output logic             q_bit
);

  logic [WIDTH:0]   shifted;
  logic [WIDTH+1:0] trial;
  logic             unused_hi;

  // rem < divisor on entry, so whichever branch is taken fits in WIDTH bits.
  always_comb begin
    shifted   = {rem, dvd_msb};
    trial     = {1'b0, shifted} - {2'b00, divisor};
    q_bit     = ~trial[WIDTH+1];
    next_rem  = q_bit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
    unused_hi = trial[WIDTH] ^ shifted[WIDTH];
  end

endmodule

// File: rtl/seq_divider.sv
// Iterative radix-2 restoring divider for UDIV/SDIV: one quotient bit per
// cycle on operand magnitudes, sign fix-up applied as the result is written.
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic [3:0]       flags
);

  localparam int unsigned CW = $clog2(WIDTH);

  div_state_t       state, state_next;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] rem, dvd, dvs;
  logic             q_neg, r_neg;

  logic             accept, last;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH-1:0] step_rem;
  logic             step_q;
  logic [WIDTH-1:0] q_raw, q_fix, r_fix;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem      (rem),
    .dvd_msb  (dvd[WIDTH-1]),
    .divisor  (dvs),
    .next_rem (step_rem),
    .q_bit    (step_q)
  );

  always_comb begin
    accept = start && (state == ST_IDLE || state == ST_DONE);
    last   = (state == ST_CALC) && (cnt == CW'(WIDTH - 1));
    a_mag  = (is_signed && a[WIDTH-1]) ? -a : a;
    b_mag  = (is_signed && b[WIDTH-1]) ? -b : b;
    q_raw  = {dvd[WIDTH-2:0], step_q};
    q_fix  = q_neg ? -q_raw : q_raw;
    r_fix  = r_neg ? -step_rem : step_rem;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (start) state_next = (b == '0) ? ST_DONE : ST_CALC;
        else       state_next = ST_IDLE;
      end
      ST_CALC: if (last) state_next = ST_DONE;
      default: state_next = ST_IDLE;
    endcase
  end

  // busy/done are registered from the next state so every output is a flop.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      cnt       <= '0;
      rem       <= '0;
      dvd       <= '0;
      dvs       <= '0;
      q_neg     <= 1'b0;
      r_neg     <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      flags     <= '0;
    end else begin
      state <= state_next;
      busy  <= (state_next == ST_CALC);
      done  <= (state_next == ST_DONE);
      if (accept) begin
        cnt   <= '0;
        rem   <= '0;
        dvd   <= a_mag;
        dvs   <= b_mag;
        q_neg <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
        r_neg <= is_signed & a[WIDTH-1];
        if (b == '0) begin
          quotient  <= '0;
          remainder <= a;
          flags     <= make_flags(1'b0, 1'b1, 1'b1);
        end
      end else if (state == ST_CALC) begin
        cnt <= cnt + CW'(1);
        rem <= step_rem;
        dvd <= q_raw;
        if (last) begin
          quotient  <= q_fix;
          remainder <= r_fix;
          flags     <= make_flags(q_fix[WIDTH-1], q_fix == '0, 1'b0);
        end
      end
    end
  end

endmodule
